// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-init sequencer.
package sccb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_REQ,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_t;

    // Table entry encodings
    localparam logic [15:0] SCCB_END       = 16'hFFFF;
    localparam logic [7:0]  SCCB_DELAY_REG = 8'hF0;

    // OV7670 write ID
    localparam logic [7:0]  OV7670_DEV_ID  = 8'h42;

endpackage

// File: rtl/sccb_init_rom.sv
// Register-init table: ROM_DEPTH x 16 synchronous ROM with one cycle of read latency.
// Contents are supplied as a packed parameter (entry i at bits [16*i +: 16]) so each
// instance can carry its own table.
module sccb_init_rom #(
    parameter int                      ROM_DEPTH  = 128,
    parameter logic [ROM_DEPTH*16-1:0] INIT_TABLE = '1
) (
    input  logic                         clk,
    input  logic [$clog2(ROM_DEPTH)-1:0] addr,
    output logic [15:0]                  data
);

    logic [15:0] mem [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_mem
        assign mem[i] = INIT_TABLE[i*16 +: 16];
    end

    // Registered read port
    always_ff @(posedge clk) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the init table and issues one SCCB write per entry through a req/ack
// handshake, with per-entry NACK retries, inter-transaction gaps and ms delays.
module sccb_init_sequencer
    import sccb_pkg::*;
#(
    parameter logic [7:0]              DEV_ID     = OV7670_DEV_ID,
    parameter int                      CLK_HZ     = 24000000,
    parameter int                      ROM_DEPTH  = 128,
    parameter int                      NUM_RETRY  = 3,
    parameter int                      GAP_CYCLES = 64,
    parameter logic [ROM_DEPTH*16-1:0] INIT_TABLE = {ROM_DEPTH{SCCB_END}}
) (
    input  logic                         XCLK,
    input  logic                         RST,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(ROM_DEPTH)-1:0] progress,
    output logic                         sccb_req,
    output logic                         sccb_rw,
    output logic [7:0]                   sccb_addr_id,
    output logic [7:0]                   sccb_addr_reg,
    output logic [7:0]                   sccb_data,
    input  logic                         sccb_ack,
    input  logic                         sccb_nack
);

    localparam int IDX_W  = $clog2(ROM_DEPTH);
    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int CYC_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int RTY_W  = (NUM_RETRY > 0) ? $clog2(NUM_RETRY + 1) : 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);
    localparam logic [CYC_W-1:0] CYC_TOP  = CYC_W'(MS_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(NUM_RETRY);
    localparam logic [GAP_W-1:0] GAP_TOP  = GAP_W'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] progress_n;
    logic [RTY_W-1:0] retry, retry_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [7:0]       ms_cnt, ms_n;
    logic [CYC_W-1:0] cyc_cnt, cyc_n;
    logic             busy_n, done_n, error_n;
    logic [7:0]       reg_n, data_n;
    logic [15:0]      rom_data;

    sccb_init_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .INIT_TABLE(INIT_TABLE)
    ) u_rom (
        .clk (XCLK),
        .addr(progress),
        .data(rom_data)
    );

    // Request is purely state-decoded so reset kills it without waiting for a clock
    assign sccb_req     = (state == S_REQ);
    assign sccb_rw      = 1'b0;
    assign sccb_addr_id = DEV_ID;

    // State and datapath registers
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            progress      <= '0;
            retry         <= '0;
            gap_cnt       <= '0;
            ms_cnt        <= '0;
            cyc_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            sccb_addr_reg <= '0;
            sccb_data     <= '0;
        end else begin
            state         <= state_n;
            progress      <= progress_n;
            retry         <= retry_n;
            gap_cnt       <= gap_n;
            ms_cnt        <= ms_n;
            cyc_cnt       <= cyc_n;
            busy          <= busy_n;
            done          <= done_n;
            error         <= error_n;
            sccb_addr_reg <= reg_n;
            sccb_data     <= data_n;
        end
    end

    // Next-state and datapath updates; advancing past the last entry ends the sequence
    always_comb begin
        state_n    = state;
        progress_n = progress;
        retry_n    = retry;
        gap_n      = gap_cnt;
        ms_n       = ms_cnt;
        cyc_n      = cyc_cnt;
        busy_n     = busy;
        done_n     = done;
        error_n    = error;
        reg_n      = sccb_addr_reg;
        data_n     = sccb_data;
        case (state)
            S_IDLE: begin
                if (start) begin
                    progress_n = '0;
                    retry_n    = '0;
                    done_n     = 1'b0;
                    error_n    = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (rom_data == SCCB_END) begin
                    state_n = S_DONE;
                end else if (rom_data[15:8] == SCCB_DELAY_REG) begin
                    ms_n    = rom_data[7:0];
                    cyc_n   = '0;
                    state_n = S_DELAY;
                end else begin
                    reg_n   = rom_data[15:8];
                    data_n  = rom_data[7:0];
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (sccb_ack) begin
                    gap_n = '0;
                    if (!sccb_nack) begin
                        retry_n = '0;
                        if (progress == LAST_IDX) begin
                            state_n = S_DONE;
                        end else begin
                            progress_n = progress + 1'b1;
                            state_n    = S_GAP;
                        end
                    end else if (retry == RTY_MAX) begin
                        state_n = S_ERR;
                    end else begin
                        retry_n = retry + 1'b1;
                        state_n = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_TOP) state_n = S_FETCH;
                else                    gap_n   = gap_cnt + 1'b1;
            end
            S_DELAY: begin
                if (ms_cnt == 8'd0 || (cyc_cnt == CYC_TOP && ms_cnt == 8'd1)) begin
                    cyc_n = '0;
                    ms_n  = '0;
                    if (progress == LAST_IDX) begin
                        state_n = S_DONE;
                    end else begin
                        progress_n = progress + 1'b1;
                        state_n    = S_FETCH;
                    end
                end else if (cyc_cnt == CYC_TOP) begin
                    cyc_n = '0;
                    ms_n  = ms_cnt - 1'b1;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            S_ERR: begin
                error_n = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench for sccb_init_sequencer: a table-walking reference model queues the
// expected SCCB writes; a monitor acts as the SCCB master, checks each request and acks it.
module tb_sccb_init_sequencer;

    localparam int         DEPTH  = 128;
    localparam int         NRTY   = 3;
    localparam int         GAP    = 64;
    localparam int         CLKHZ  = 1000;
    localparam int         MS_CYC = CLKHZ / 1000;
    localparam int         NI     = 3;
    localparam logic [7:0] DEV    = 8'h42;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        bit         nk;
        int         lat;
    } item_t;

    // Table k: 0 = two writes, 1 = delay then write, 2 = DEPTH writes with no end marker
    function automatic logic [15:0] entry(input int k, input int i);
        logic [7:0] b;
        b = i[7:0];
        case (k)
            0:       return (i == 0) ? 16'h1280 : (i == 1) ? 16'h1101 : 16'hFFFF;
            1:       return (i == 0) ? 16'hF002 : (i == 1) ? 16'h3A04 : 16'hFFFF;
            default: return {b, b ^ 8'hA5};
        endcase
    endfunction

    function automatic logic [DEPTH*16-1:0] mk_table(input int k);
        logic [DEPTH*16-1:0] t;
        t = '0;
        for (int i = 0; i < DEPTH; i++) t[i*16 +: 16] = entry(k, i);
        return t;
    endfunction

    logic       XCLK = 1'b0;
    logic       RST;
    logic       start_v [NI];
    logic       ack_v   [NI];
    logic       nack_v  [NI];
    logic       busy_v  [NI];
    logic       done_v  [NI];
    logic       err_v   [NI];
    logic       req_v   [NI];
    logic       rw_v    [NI];
    logic [6:0] prog_v  [NI];
    logic [7:0] id_v    [NI];
    logic [7:0] reg_v   [NI];
    logic [7:0] dat_v   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sccb_init_sequencer #(
            .DEV_ID    (DEV),
            .CLK_HZ    (CLKHZ),
            .ROM_DEPTH (DEPTH),
            .NUM_RETRY (NRTY),
            .GAP_CYCLES(GAP),
            .INIT_TABLE(mk_table(g))
        ) u_dut (
            .XCLK         (XCLK),
            .RST          (RST),
            .start        (start_v[g]),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .error        (err_v[g]),
            .progress     (prog_v[g]),
            .sccb_req     (req_v[g]),
            .sccb_rw      (rw_v[g]),
            .sccb_addr_id (id_v[g]),
            .sccb_addr_reg(reg_v[g]),
            .sccb_data    (dat_v[g]),
            .sccb_ack     (ack_v[g]),
            .sccb_nack    (nack_v[g])
        );
    end

    always #5 XCLK = ~XCLK;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    sel    = 0;
    bit    no_ack = 1'b0;
    int    t_ref  = 0;
    item_t exp_q [$];
    bit    m_done, m_err;
    int    m_prog;

    always @(posedge XCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk the table by its rules, deciding each NACK up front
    task automatic model_run(input int s, input int pct, input int maxn);
        int          idx, tries, extra;
        bit          first, fin, nk;
        logic [15:0] e;
        idx = 0; tries = 0; extra = 0; first = 1; fin = 0;
        m_done = 0; m_err = 0;
        exp_q.delete();
        while (!fin) begin
            e = entry(s, idx);
            if (e == 16'hFFFF) begin
                m_done = 1; fin = 1;
            end else if (e[15:8] == 8'hF0) begin
                extra += 2 + ((e[7:0] == 0) ? 1 : int'(e[7:0]) * MS_CYC);
                if (idx == DEPTH - 1) begin m_done = 1; fin = 1; end
                else idx++;
            end else begin
                nk = (tries < maxn) && ($urandom_range(0, 99) < pct);
                exp_q.push_back('{e[15:8], e[7:0], nk, 2 + (first ? 0 : GAP) + extra});
                first = 0; extra = 0;
                if (!nk) begin
                    tries = 0;
                    if (idx == DEPTH - 1) begin m_done = 1; fin = 1; end
                    else idx++;
                end else if (tries == NRTY) begin
                    m_err = 1; fin = 1;
                end else begin
                    tries++;
                end
            end
        end
        m_prog = idx;
    endtask

    // Monitor / SCCB master model: check each request against the queue, then ack it
    initial begin : monitor
        item_t e;
        int    s, d, r;
        for (int i = 0; i < NI; i++) begin ack_v[i] = 0; nack_v[i] = 0; end
        forever begin
            @(negedge XCLK);
            s = sel;
            if (RST === 1'b0 && !no_ack && req_v[s] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got reg %0h data %0h want no request", reg_v[s], dat_v[s]);
                    e = '{reg_v[s], dat_v[s], 1'b0, 0};
                end else begin
                    e = exp_q.pop_front();
                    chk("req_latency", cyc - t_ref, e.lat);
                    chk("req_reg", reg_v[s], e.r);
                    chk("req_data", dat_v[s], e.d);
                    chk("req_id", id_v[s], DEV);
                    chk("req_rw", rw_v[s], 0);
                end
                d = $urandom_range(0, 3);
                for (int k = 0; k < d; k++) begin
                    @(negedge XCLK);
                    chk("req_hold", {req_v[s], reg_v[s], dat_v[s]}, {1'b1, e.r, e.d});
                end
                ack_v[s] = 1; nack_v[s] = e.nk; t_ref = cyc + 1;
                @(negedge XCLK);
                ack_v[s] = 0; nack_v[s] = 0;
                chk("req_drop", req_v[s], 0);
                // stray ack while not requesting must be ignored
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(1, 10);
                    repeat (r) @(negedge XCLK);
                    ack_v[s] = 1; nack_v[s] = 1'($urandom_range(0, 1));
                    @(negedge XCLK);
                    ack_v[s] = 0; nack_v[s] = 0;
                end
            end
        end
    end

    task automatic run_scn(input int s, input int pct, input int maxn, input bit mid);
        int n;
        sel = s;
        model_run(s, pct, maxn);
        @(negedge XCLK);
        start_v[s] = 1; t_ref = cyc + 1;
        @(negedge XCLK);
        start_v[s] = 0;
        chk("busy_after_start", busy_v[s], 1);
        chk("done_cleared", done_v[s], 0);
        chk("error_cleared", err_v[s], 0);
        n = 0;
        while (busy_v[s] === 1'b1 && n < 30000) begin
            @(negedge XCLK);
            n++;
            start_v[s] = (mid && n == 500);
        end
        start_v[s] = 0;
        chk("finish_in_budget", n < 30000, 1);
        chk("done", done_v[s], m_done);
        chk("error", err_v[s], m_err);
        chk("progress", prog_v[s], m_prog);
        chk("all_reqs_issued", exp_q.size(), 0);
        repeat (30) @(negedge XCLK);
    endtask

    task automatic chk_reset_state(input int s);
        chk("rst_busy", busy_v[s], 0);
        chk("rst_done", done_v[s], 0);
        chk("rst_error", err_v[s], 0);
        chk("rst_req", req_v[s], 0);
        chk("rst_progress", prog_v[s], 0);
        chk("rst_addr_reg", reg_v[s], 0);
        chk("rst_data", dat_v[s], 0);
    endtask

    initial begin : stim
        int n;
        RST = 1;
        for (int i = 0; i < NI; i++) start_v[i] = 0;
        repeat (3) @(negedge XCLK);
        for (int i = 0; i < NI; i++) chk_reset_state(i);
        chk("const_rw", rw_v[0], 0);
        chk("const_id", id_v[0], DEV);
        RST = 0;
        repeat (2) @(negedge XCLK);

        run_scn(0, 0, 0, 0);       // two writes, all acked
        run_scn(1, 0, 0, 0);       // 2 ms delay then a write
        run_scn(0, 100, 2, 0);     // two NACKs on entry 0, then success
        run_scn(0, 100, NRTY + 1, 0); // always NACK -> error at index 0

        // reset while a request is pending
        sel = 0; no_ack = 1; exp_q.delete();
        @(negedge XCLK); start_v[0] = 1;
        @(negedge XCLK); start_v[0] = 0;
        n = 0;
        while (req_v[0] !== 1'b1 && n < 50) begin @(negedge XCLK); n++; end
        chk("req_before_reset", req_v[0], 1);
        #2 RST = 1;
        #1 chk_reset_state(0);
        @(negedge XCLK); RST = 0; no_ack = 0;
        run_scn(0, 0, 0, 0);       // re-runs from index 0

        run_scn(2, 15, NRTY, 1);   // full table, no end marker, ignored mid-run start

        repeat (4) run_scn($urandom_range(0, 1), $urandom_range(0, 60), NRTY + 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
